// File: rtl/col_dot_mac.sv
// col_dot_mac: 3x3 kernel dot product plus bias over im2col columns, one tap per cycle.
// Defining COL_MAC_RELU_EN clamps negative results to zero.
module col_dot_mac #(
    parameter int DATA_W    = 8,
    parameter int ACC_W     = 20,
    parameter int KTAPS     = 9,
    parameter int OUT_COUNT = 676
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    weight_wr_en,
    input  logic [3:0]              weight_addr,
    input  logic [DATA_W-1:0]       weight_data,
    input  logic [15:0]             bias,
    input  logic                    col_valid,
    output logic                    col_ready,
    input  logic [KTAPS*DATA_W-1:0] col_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ACC_W-1:0]        out_data,
    output logic                    out_last,
    output logic                    frame_done,
    output logic                    busy
);
    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
    localparam logic [3:0] LAST_TAP = 4'(KTAPS - 1);
    localparam logic [9:0] LAST_OUT = 10'(OUT_COUNT - 1);
    state_t state, state_nxt;
    logic signed [DATA_W-1:0] weights [KTAPS];
    logic signed [DATA_W-1:0] kern [KTAPS];
    logic [KTAPS*DATA_W-1:0] pix;
    logic [DATA_W-1:0] pix_sel;
    logic signed [2*DATA_W:0] prod;
    logic [ACC_W-1:0] acc, sum, load;
    logic [3:0] tap;
    logic [9:0] out_count;
    logic accept, out_fire, wr_ok;
    assign col_ready = state == IDLE && !reset;
    assign accept    = col_ready && col_valid;
    assign out_valid = state == OUT;
    assign out_fire  = out_valid && out_ready;
    assign out_last  = out_valid && out_count == LAST_OUT;
    assign busy      = state != IDLE;
    assign wr_ok     = weight_wr_en && state == IDLE && weight_addr <= LAST_TAP;
    assign pix_sel   = pix[tap*DATA_W +: DATA_W];
    assign prod      = (2*DATA_W+1)'($signed({1'b0, pix_sel})) * (2*DATA_W+1)'(kern[tap]);
    assign sum       = acc + ACC_W'(prod);
`ifdef COL_MAC_RELU_EN
    assign load = sum[ACC_W-1] ? '0 : sum;
`else
    assign load = sum;
`endif
    always_comb begin
        state_nxt = state == IDLE ? (accept ? MAC : IDLE)
                  : state == MAC  ? (tap == LAST_TAP ? OUT : MAC)
                  : (out_ready ? IDLE : OUT);
    end
    // The kernel is snapshotted at acceptance so a same-cycle write only affects later columns.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            weights    <= '{default: '0};
            kern       <= '{default: '0};
            pix        <= '0;
            acc        <= '0;
            tap        <= '0;
            out_count  <= '0;
            out_data   <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            frame_done <= out_fire && out_last;
            if (wr_ok) weights[weight_addr] <= weight_data;
            if (accept) begin
                pix  <= col_data;
                kern <= weights;
                acc  <= ACC_W'($signed(bias));
                tap  <= '0;
            end
            if (state == MAC) begin
                acc <= sum;
                tap <= tap + 1'b1;
                if (tap == LAST_TAP) out_data <= load;
            end
            if (out_fire) out_count <= out_last ? '0 : out_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_col_dot_mac.sv
// tb_col_dot_mac: randomized self-checking bench for col_dot_mac against an arithmetic reference model.
module tb_col_dot_mac;
    logic clk = 1'b0, reset, weight_wr_en, col_valid, out_ready;
    logic [3:0] weight_addr;
    logic [7:0] weight_data;
    logic [15:0] bias;
    logic [71:0] col_data;
    logic col_ready, out_valid, out_last, frame_done, busy;
    logic [19:0] out_data;
    int checks = 0, errors = 0;
    int mw[9];
    int mcount = 0;

    col_dot_mac dut (
        .clk(clk), .reset(reset), .weight_wr_en(weight_wr_en), .weight_addr(weight_addr),
        .weight_data(weight_data), .bias(bias), .col_valid(col_valid), .col_ready(col_ready),
        .col_data(col_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .frame_done(frame_done), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int model(input logic [71:0] c, input int b);
        int s = b;
        for (int t = 0; t < 9; t++) s += int'(c[8*t +: 8]) * mw[t];
`ifdef COL_MAC_RELU_EN
        if (s < 0) s = 0;
`endif
        return s;
    endfunction

    function automatic logic [71:0] rand_col();
        return {8'($urandom), 32'($urandom), 32'($urandom)};
    endfunction

    function automatic int rand_w();
        return int'($urandom_range(0, 255)) - 128;
    endfunction

    function automatic int rand_b();
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    task automatic write_w(input int a, input int d);
        weight_wr_en = 1'b1;
        weight_addr  = a[3:0];
        weight_data  = d[7:0];
        step();
        weight_wr_en = 1'b0;
        if (a < 9) mw[a] = d;
    endtask

    task automatic send_col(input logic [71:0] c, input int b, input bit junk, output int lat,
                            output int res, output logic last, output logic post_v, output logic post_fd);
        int n = 0;
        col_data  = c;
        bias      = b[15:0];
        col_valid = 1'b1;
        out_ready = 1'b1;
        while (!col_ready && n < 50) begin step(); n++; end
        step();
        weight_wr_en = junk;
        weight_addr  = 4'd4;
        col_valid    = 1'b0;
        col_data     = rand_col();
        bias         = 16'($urandom);
        lat = 0;
        while (!out_valid && lat < 50) begin
            weight_data = 8'($urandom);
            step();
            lat++;
        end
        res  = int'($signed(out_data));
        last = out_last;
        step();
        weight_wr_en = 1'b0;
        post_v  = out_valid;
        post_fd = frame_done;
        if (lat < 50) mcount = (mcount + 1) % 676;
    endtask

    task automatic test_reset();
        reset = 1'b1; weight_wr_en = 1'b0; weight_addr = '0; weight_data = '0; bias = '0;
        col_valid = 1'b0; col_data = '0; out_ready = 1'b0;
        for (int t = 0; t < 9; t++) mw[t] = 0;
        repeat (3) step();
        checks++; if (col_ready !== 1'b0) begin errors++; $display("FAIL reset_col_ready got %b want 0", col_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (out_data !== 20'd0) begin errors++; $display("FAIL reset_out_data got %0h want 0", out_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (frame_done !== 1'b0 || out_last !== 1'b0) begin errors++; $display("FAIL reset_flags got %b%b want 00", frame_done, out_last); end
        reset = 1'b0;
        #1;
        checks++; if (col_ready !== 1'b1) begin errors++; $display("FAIL release_col_ready got %b want 1", col_ready); end
        step();
    endtask

    task automatic test_basic();
        int lat, res; logic last, pv, pf;
        for (int t = 0; t < 9; t++) write_w(t, 1);
        send_col({9{8'd1}}, 0, 1'b0, lat, res, last, pv, pf);
        checks++; if (lat != 9) begin errors++; $display("FAIL basic_latency got %0d want 9", lat); end
        checks++; if (res != 9) begin errors++; $display("FAIL basic_data got %0d want 9", res); end
        checks++; if (pv !== 1'b0) begin errors++; $display("FAIL basic_valid_drop got %b want 0", pv); end
    endtask

    task automatic test_extreme();
        int lat, res, exp_neg; logic last, pv, pf;
`ifdef COL_MAC_RELU_EN
        exp_neg = 0;
`else
        exp_neg = -326528;
`endif
        for (int t = 0; t < 9; t++) write_w(t, -128);
        send_col({9{8'hff}}, -32768, 1'b0, lat, res, last, pv, pf);
        checks++; if (res != exp_neg) begin errors++; $display("FAIL extreme_neg got %0d want %0d", res, exp_neg); end
        for (int t = 0; t < 9; t++) write_w(t, 127);
        send_col({9{8'hff}}, 32767, 1'b0, lat, res, last, pv, pf);
        checks++; if (res != model({9{8'hff}}, 32767)) begin errors++; $display("FAIL extreme_pos got %0d want %0d", res, model({9{8'hff}}, 32767)); end
    endtask

    task automatic test_backpressure();
        logic [71:0] c; int b, e, n;
        for (int t = 0; t < 9; t++) write_w(t, rand_w());
        c = rand_col(); b = rand_b(); e = model(c, b);
        col_data = c; bias = b[15:0]; col_valid = 1'b1; out_ready = 1'b0;
        step();
        col_data = rand_col();
        n = 0;
        while (!out_valid && n < 50) begin step(); n++; end
        checks++; if (n != 9) begin errors++; $display("FAIL bp_latency got %0d want 9", n); end
        for (int i = 0; i < 5; i++) begin
            checks++; if (int'($signed(out_data)) != e || out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold%0d got %0d/%b want %0d/1", i, $signed(out_data), out_valid, e); end
            checks++; if (col_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL bp_ready%0d got ready=%b busy=%b want 0/1", i, col_ready, busy); end
            col_data = rand_col();
            step();
        end
        col_valid = 1'b0; out_ready = 1'b1;
        step();
        mcount = (mcount + 1) % 676;
        checks++; if (out_valid !== 1'b0 || col_ready !== 1'b1) begin errors++; $display("FAIL bp_release got valid=%b ready=%b want 0/1", out_valid, col_ready); end
    endtask

    task automatic test_weight_timing();
        logic [71:0] c; int b, e, lat, res, nw; logic last, pv, pf;
        for (int t = 0; t < 9; t++) write_w(t, rand_w());
        c = rand_col(); b = rand_b(); e = model(c, b);
        send_col(c, b, 1'b1, lat, res, last, pv, pf);
        checks++; if (res != e) begin errors++; $display("FAIL wt_mac_write got %0d want %0d", res, e); end
        write_w(12, rand_w());
        c = rand_col(); b = rand_b(); e = model(c, b);
        send_col(c, b, 1'b0, lat, res, last, pv, pf);
        checks++; if (res != e) begin errors++; $display("FAIL wt_addr12 got %0d want %0d", res, e); end
        nw = mw[4] > 0 ? mw[4] - 100 : mw[4] + 100;
        write_w(4, nw);
        c = rand_col(); c[39:32] = 8'd200; b = rand_b(); e = model(c, b);
        send_col(c, b, 1'b0, lat, res, last, pv, pf);
        checks++; if (res != e) begin errors++; $display("FAIL wt_idle_write got %0d want %0d", res, e); end
        c = rand_col(); c[39:32] = 8'd150; b = rand_b(); e = model(c, b);
        nw = rand_w();
        weight_wr_en = 1'b1; weight_addr = 4'd4; weight_data = nw[7:0];
        send_col(c, b, 1'b0, lat, res, last, pv, pf);
        mw[4] = nw;
        checks++; if (res != e) begin errors++; $display("FAIL wt_same_cycle got %0d want %0d", res, e); end
        e = model(c, b);
        send_col(c, b, 1'b0, lat, res, last, pv, pf);
        checks++; if (res != e) begin errors++; $display("FAIL wt_after_same got %0d want %0d", res, e); end
    endtask

    task automatic test_reset_mid_mac();
        logic [71:0] c; int b, e, lat, res, seen; logic last, pv, pf;
        for (int t = 0; t < 9; t++) write_w(t, rand_w() | 1);
        col_data = rand_col(); bias = 16'($urandom); col_valid = 1'b1; out_ready = 1'b1;
        step();
        col_valid = 1'b0;
        repeat (5) step();
        #2 reset = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || out_data !== 20'd0 || busy !== 1'b0 || col_ready !== 1'b0) begin
            errors++; $display("FAIL midreset_outputs got v=%b d=%0h busy=%b rdy=%b want 0000", out_valid, out_data, busy, col_ready); end
        @(posedge clk); #1 reset = 1'b0;
        for (int t = 0; t < 9; t++) mw[t] = 0;
        mcount = 0;
        seen = 0;
        repeat (15) begin step(); if (out_valid) seen++; end
        checks++; if (seen != 0) begin errors++; $display("FAIL midreset_no_valid got %0d want 0", seen); end
        c = rand_col(); b = rand_b(); e = model(c, b);
        send_col(c, b, 1'b0, lat, res, last, pv, pf);
        checks++; if (res != e) begin errors++; $display("FAIL midreset_zero_w got %0d want %0d", res, e); end
    endtask

    task automatic test_frame();
        logic [71:0] c; int b, e, lat, res, lasts; logic last, pv, pf;
        reset = 1'b1; step(); reset = 1'b0;
        for (int t = 0; t < 9; t++) mw[t] = 0;
        mcount = 0; lasts = 0;
        for (int t = 0; t < 9; t++) write_w(t, rand_w());
        for (int i = 0; i < 677; i++) begin
            c = rand_col(); b = rand_b(); e = model(c, b);
            send_col(c, b, 1'b0, lat, res, last, pv, pf);
            if (last) lasts++;
            checks++; if (res != e || lat != 9) begin errors++; $display("FAIL frame_data%0d got %0d lat %0d want %0d lat 9", i, res, lat, e); end
            checks++; if (last !== (i == 675)) begin errors++; $display("FAIL frame_last%0d got %b want %b", i, last, i == 675); end
            checks++; if (pf !== (i == 675)) begin errors++; $display("FAIL frame_done%0d got %b want %b", i, pf, i == 675); end
            if (i == 675) begin
                step();
                checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL frame_done_width got %b want 0", frame_done); end
            end
        end
        checks++; if (lasts != 1) begin errors++; $display("FAIL frame_last_count got %0d want 1", lasts); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extreme();
        test_backpressure();
        test_weight_timing();
        test_reset_mid_mac();
        test_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
